// File: rtl/toll_lane_allocator.sv
// Toll plaza lane allocator: assigns each arriving vehicle to the least-occupied
// eligible lane and drains every lane autonomously with a per-lane service timer.
module toll_lane_allocator #(
   parameter int unsigned NUM_LANES      = 6,
   parameter int unsigned CNT_W          = 3,
   parameter int unsigned PRIO_LANES     = 1,
   parameter int unsigned CASH_LANES     = 2,
   parameter int unsigned SERVICE_CYCLES = 4,
   localparam int unsigned LANE_W        = $clog2(NUM_LANES)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         arr_valid,
   input  logic                         arr_priority,
   input  logic                         arr_cash,
   input  logic [1:0]                   arr_vhtype,
   output logic                         arr_ready,
   output logic                         sel_valid,
   output logic [LANE_W-1:0]            sel_lane,
   output logic [1:0]                   sel_vhtype,
   output logic [NUM_LANES*CNT_W-1:0]   lane_count,
   output logic [NUM_LANES-1:0]         lane_full,
   output logic [NUM_LANES-1:0]         depart,
   output logic [15:0]                  served_total
);

   localparam int unsigned TMR_W   = $clog2(2*SERVICE_CYCLES+1);
   localparam int unsigned CASH_LO = NUM_LANES - CASH_LANES;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]     count_q [NUM_LANES];
   logic [CNT_W-1:0]     count_d [NUM_LANES];
   logic [TMR_W-1:0]     timer_q [NUM_LANES];
   logic [TMR_W-1:0]     timer_d [NUM_LANES];
   logic [NUM_LANES-1:0] lane_full_q, lane_full_d;
   logic [NUM_LANES-1:0] depart_q, depart_d;
   logic                 sel_valid_q, sel_valid_d;
   logic [LANE_W-1:0]    sel_lane_q, sel_lane_d;
   logic [1:0]           sel_vhtype_q, sel_vhtype_d;
   logic [15:0]          served_q, served_d;

   logic [NUM_LANES-1:0] prio_mask, cash_mask, elec_mask;
   logic [NUM_LANES-1:0] full, elig, avail, hit;
   logic [CNT_W-1:0]     best_cnt;
   logic [LANE_W-1:0]    pick;
   logic                 found;
   logic                 accept;
   logic [15:0]          ndep;

   // Last timer value before a departure; cash lanes serve twice as slowly.
   function automatic logic [TMR_W-1:0] t_last(input int unsigned lane);
      return (lane >= CASH_LO) ? TMR_W'(2*SERVICE_CYCLES-1) : TMR_W'(SERVICE_CYCLES-1);
   endfunction

   always_comb begin
      prio_mask = '0;
      cash_mask = '0;
      elec_mask = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         prio_mask[i] = (i < PRIO_LANES);
         cash_mask[i] = (i >= CASH_LO);
         elec_mask[i] = (i >= PRIO_LANES) && (i < CASH_LO);
      end
   end

   // Eligibility and min-count selection, lowest index wins ties.
   always_comb begin
      full = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         full[i] = (count_q[i] == CNT_MAX);
      end
      if (arr_priority) begin
         elig = (|(prio_mask & ~full)) ? prio_mask : '1;
      end else if (arr_cash) begin
         elig = cash_mask;
      end else begin
         elig = elec_mask;
      end
      avail     = elig & ~full;
      arr_ready = enable & (|avail);
      accept    = arr_valid & arr_ready;
      found     = 1'b0;
      best_cnt  = '1;
      pick      = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         if (avail[i] && (!found || count_q[i] < best_cnt)) begin
            found    = 1'b1;
            best_cnt = count_q[i];
            pick     = LANE_W'(i);
         end
      end
      hit = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         hit[i] = accept && (pick == LANE_W'(i));
      end
   end

   // Per-lane service timers, occupancy update and departure accounting.
   always_comb begin
      served_d     = served_q;
      depart_d     = '0;
      ndep         = '0;
      sel_valid_d  = 1'b0;
      sel_lane_d   = sel_lane_q;
      sel_vhtype_d = sel_vhtype_q;
      lane_full_d  = full;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         count_d[i] = count_q[i];
         timer_d[i] = timer_q[i];
      end
      if (enable) begin
         for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (count_q[i] != '0) begin
               if (timer_q[i] == t_last(i)) begin
                  depart_d[i] = 1'b1;
                  timer_d[i]  = '0;
               end else begin
                  timer_d[i] = timer_q[i] + 1'b1;
               end
            end
            count_d[i]     = count_q[i] + CNT_W'(hit[i]) - CNT_W'(depart_d[i]);
            lane_full_d[i] = (count_d[i] == CNT_MAX);
            ndep           = ndep + 16'(depart_d[i]);
         end
         served_d = served_q + ndep;
         if (accept) begin
            sel_valid_d  = 1'b1;
            sel_lane_d   = pick;
            sel_vhtype_d = arr_vhtype;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_LANES; i++) begin
            count_q[i] <= '0;
            timer_q[i] <= '0;
         end
         lane_full_q  <= '0;
         depart_q     <= '0;
         sel_valid_q  <= 1'b0;
         sel_lane_q   <= '0;
         sel_vhtype_q <= '0;
         served_q     <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_LANES; i++) begin
            count_q[i] <= count_d[i];
            timer_q[i] <= timer_d[i];
         end
         lane_full_q  <= lane_full_d;
         depart_q     <= depart_d;
         sel_valid_q  <= sel_valid_d;
         sel_lane_q   <= sel_lane_d;
         sel_vhtype_q <= sel_vhtype_d;
         served_q     <= served_d;
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_cnt
      assign lane_count[g*CNT_W +: CNT_W] = count_q[g];
   end

   assign lane_full    = lane_full_q;
   assign depart       = depart_q;
   assign sel_valid    = sel_valid_q;
   assign sel_lane     = sel_lane_q;
   assign sel_vhtype   = sel_vhtype_q;
   assign served_total = served_q;

endmodule
